// File: rtl/hamdec_pkg.sv
// Shared types and helpers for the Hamming(15,11) decode engine.
package hamdec_pkg;

  localparam int RD_BASE_D = 64;
  localparam int WR_BASE_D = 94;
  localparam int NWORDS_D  = 15;

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, WR_LO, WR_HI, CNT, DONE
  } state_t;

  // s[k] is the parity over every codeword position whose index has bit k set
  function automatic logic [3:0] syndrome(input logic [15:1] cw);
    logic [3:0] s;
    s = '0;
    for (int p = 1; p < 16; p++)
      for (int k = 0; k < 4; k++)
        if (p[k]) s[k] ^= cw[p];
    return s;
  endfunction

endpackage

// File: rtl/hamming15_correct.sv
// Combinational single-error corrector: codeword in, corrected 11-bit message and syndrome out.
module hamming15_correct
  import hamdec_pkg::*;
(
  input  logic [15:1] cw,
  output logic [11:1] d,
  output logic [3:0]  syn
);

  logic [15:1] fix;

  assign syn = syndrome(cw);

  // A nonzero syndrome names the flipped position directly, parity bits included
  always_comb begin
    fix = cw;
    if (syn != 4'd0) fix[syn] = ~cw[syn];
  end

  assign d = {fix[15:9], fix[7:5], fix[3]};

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-side Hamming(15,11) decoder: on req, corrects NWORDS codewords and writes the messages back.
// Optional error counter and trailing count write enabled by HAMDEC_ERRCNT_EN.
module hamming_dec_engine
  import hamdec_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RD_BASE = RD_BASE_D,
  parameter int WR_BASE = WR_BASE_D,
  parameter int NWORDS  = NWORDS_D
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wr_data
);

  localparam int IW = $clog2(NWORDS + 1);

  state_t        state, nxt;
  logic [IW-1:0] i;
  logic [DW-1:0] lo_q;
  logic [11:1]   d_c, d_q;
  logic [3:0]    syn;
  logic          last;
  logic [AW-1:0] off;
  logic          unused_hi;

  assign last      = (i == IW'(NWORDS - 1));
  assign off       = AW'({i, 1'b0});
  assign unused_hi = ^mem_rd_data[DW-1:7];

  // High byte is sampled straight off the bus in RD_HI, so d is ready at that edge
  hamming15_correct u_corr (
    .cw  ({mem_rd_data[6:0], lo_q[7:0]}),
    .d   (d_c),
    .syn (syn)
  );

`ifdef HAMDEC_ERRCNT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (state == IDLE && req)   cnt <= '0;
    else if (state == RD_HI)         cnt <= cnt + {7'd0, |syn};
  end
`else
  logic unused_syn;
  assign unused_syn = ^syn;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (req) nxt = RD_LO;
      RD_LO: nxt = RD_HI;
      RD_HI: nxt = WR_LO;
      WR_LO: nxt = WR_HI;
`ifdef HAMDEC_ERRCNT_EN
      WR_HI: nxt = last ? CNT : RD_LO;
      CNT:   nxt = DONE;
`else
      WR_HI: nxt = last ? DONE : RD_LO;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      RD_LO: mem_addr = AW'(RD_BASE) + off;
      RD_HI: mem_addr = AW'(RD_BASE) + off + AW'(1);
      WR_LO: begin
        mem_addr    = AW'(WR_BASE) + off;
        mem_wr_en   = 1'b1;
        mem_wr_data = DW'(d_q[8:1]);
      end
      WR_HI: begin
        mem_addr    = AW'(WR_BASE) + off + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = DW'(d_q[11:9]);
      end
`ifdef HAMDEC_ERRCNT_EN
      CNT: begin
        mem_addr    = AW'(WR_BASE + 2 * NWORDS);
        mem_wr_en   = 1'b1;
        mem_wr_data = DW'(cnt);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i    <= '0;
      lo_q <= '0;
      d_q  <= '0;
      ack  <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (req) begin
                 i   <= '0;
                 ack <= 1'b0;
               end
        RD_LO: lo_q <= mem_rd_data;
        RD_HI: d_q  <= d_c;
        WR_HI: if (!last) i <= i + IW'(1);
        DONE:  ack <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
